// File: rtl/rx_pkg.sv
// Shared constants and state encoding for the rx sample buffer and its sweep sequencer.
package rx_pkg;

    localparam int RX_SAMPLE_W = 16;
    localparam int RX_AW       = 9;
    localparam int RX_MEM_LEN  = 510;
    localparam int RX_TAPS     = 508;

    typedef enum logic {
        SWEEP_IDLE,
        SWEEP_RUN
    } sweep_state_e;

endpackage

// File: rtl/rx_ring_ptr.sv
// Circular buffer pointer: load has priority over increment, increment over decrement.
module rx_ring_ptr
    import rx_pkg::*;
#(
    parameter int AW            = RX_AW,
    parameter int MEMORY_LENGTH = RX_MEM_LEN
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    output logic [AW-1:0] o_ptr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEMORY_LENGTH - 1);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
        end else if (i_dec) begin
            r_ptr <= (r_ptr == '0) ? LAST_ADDR : r_ptr - 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rx_buffer_sweep_sequencer.sv
// Writes ADC samples into a circular BRAM and runs one newest-to-oldest read sweep per
// sample, with a one-deep request queue and a sticky overrun flag.
module rx_buffer_sweep_sequencer
    import rx_pkg::*;
#(
    parameter int MEMORY_LENGTH = RX_MEM_LEN,
    parameter int TAPS          = RX_TAPS,
    parameter int AW            = RX_AW
) (
    input  logic                   crx_clk,
    input  logic                   rrx_rst_n,
    input  logic                   erx_en,
    input  logic                   sample_valid,
    input  logic [RX_SAMPLE_W-1:0] sample_in,
    input  logic                   clr_overrun,
    output logic                   bram_wr_en,
    output logic [AW-1:0]          bram_wr_addr,
    output logic [RX_SAMPLE_W-1:0] bram_wr_data,
    output logic                   bram_rd_en,
    output logic [AW-1:0]          bram_rd_addr,
    output logic                   tap_valid,
    output logic [AW-1:0]          tap_index,
    output logic                   tap_first,
    output logic                   tap_last,
    output logic                   busy,
    output logic                   primed,
    output logic                   overrun
);

    localparam logic [AW-1:0] TAPS_LAST = AW'(TAPS - 1);
    localparam logic [AW-1:0] TAPS_FULL = AW'(TAPS);

    sweep_state_e             r_state;
    logic                     r_pending;
    logic [AW-1:0]            r_pend_addr;
    logic [AW-1:0]            r_tap;
    logic [AW-1:0]            r_fill;
    logic                     r_wr_en;
    logic [AW-1:0]            r_wr_addr;
    logic [RX_SAMPLE_W-1:0]   r_wr_data;
    logic                     r_tap_valid;
    logic [AW-1:0]            r_tap_index;
    logic                     r_tap_first;
    logic                     r_tap_last;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_rd_issue;
    logic                     w_last_read;
    logic                     w_start;
    logic                     w_drop;
    logic [AW-1:0]            w_wptr;
    logic [AW-1:0]            w_rd_ptr;

    assign w_accept    = sample_valid && erx_en;
    assign w_rd_issue  = (r_state == SWEEP_RUN);
    assign w_last_read = w_rd_issue && (r_tap == TAPS_LAST);
    // A queued request is taken either from idle or back-to-back on the final read.
    assign w_start     = r_pending && ((r_state == SWEEP_IDLE) || w_last_read);
    assign w_drop      = w_accept && r_pending && !w_start;

    rx_ring_ptr #(
        .AW            (AW),
        .MEMORY_LENGTH (MEMORY_LENGTH)
    ) u_wr_ptr (
        .i_clk      (crx_clk),
        .i_rst_n    (rrx_rst_n),
        .i_inc      (w_accept),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_wptr)
    );

    rx_ring_ptr #(
        .AW            (AW),
        .MEMORY_LENGTH (MEMORY_LENGTH)
    ) u_rd_ptr (
        .i_clk      (crx_clk),
        .i_rst_n    (rrx_rst_n),
        .i_inc      (1'b0),
        .i_dec      (w_rd_issue && !w_last_read),
        .i_load     (w_start),
        .i_load_val (r_pend_addr),
        .o_ptr      (w_rd_ptr)
    );

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_pending   <= 1'b0;
            r_pend_addr <= '0;
            r_fill      <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_wr_en   <= w_accept;
            r_wr_addr <= w_wptr;
            r_wr_data <= sample_in;
            if (w_accept) begin
                r_pending   <= 1'b1;
                r_pend_addr <= w_wptr;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
            if (w_accept && (r_fill != TAPS_FULL)) begin
                r_fill <= r_fill + 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_state     <= SWEEP_IDLE;
            r_tap       <= '0;
            r_tap_valid <= 1'b0;
            r_tap_index <= '0;
            r_tap_first <= 1'b0;
            r_tap_last  <= 1'b0;
        end else begin
            // Tap strobes trail the read issue by the BRAM read latency.
            r_tap_valid <= w_rd_issue;
            r_tap_index <= w_rd_issue ? r_tap : '0;
            r_tap_first <= w_rd_issue && (r_tap == '0);
            r_tap_last  <= w_last_read;
            unique case (r_state)
                SWEEP_IDLE: begin
                    if (r_pending) begin
                        r_state <= SWEEP_RUN;
                        r_tap   <= '0;
                    end
                end
                SWEEP_RUN: begin
                    if (w_last_read) begin
                        r_tap <= '0;
                        if (!r_pending) begin
                            r_state <= SWEEP_IDLE;
                        end
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                default: r_state <= SWEEP_IDLE;
            endcase
        end
    end

    assign bram_wr_en   = r_wr_en;
    assign bram_wr_addr = r_wr_addr;
    assign bram_wr_data = r_wr_data;
    assign bram_rd_en   = w_rd_issue;
    assign bram_rd_addr = w_rd_ptr;
    assign tap_valid    = r_tap_valid;
    assign tap_index    = r_tap_index;
    assign tap_first    = r_tap_first;
    assign tap_last     = r_tap_last;
    assign busy         = w_rd_issue || r_pending || r_tap_valid;
    assign primed       = (r_fill == TAPS_FULL);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_rx_buffer_sweep_sequencer.sv
// Scoreboard bench: stimulus queues expected writes, reads and taps; a negedge monitor pops them.
module tb_rx_buffer_sweep_sequencer;

    localparam int ML   = 10;
    localparam int TAPS = 7;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sv = 1'b0;
    logic          clr = 1'b0;
    logic [15:0]   sin = '0;
    logic          bram_wr_en;
    logic [AW-1:0] bram_wr_addr;
    logic [15:0]   bram_wr_data;
    logic          bram_rd_en;
    logic [AW-1:0] bram_rd_addr;
    logic          tap_valid;
    logic [AW-1:0] tap_index;
    logic          tap_first;
    logic          tap_last;
    logic          busy;
    logic          primed;
    logic          overrun;

    rx_buffer_sweep_sequencer #(
        .MEMORY_LENGTH (ML),
        .TAPS          (TAPS),
        .AW            (AW)
    ) dut (
        .crx_clk      (clk),
        .rrx_rst_n    (rst_n),
        .erx_en       (en),
        .sample_valid (sv),
        .sample_in    (sin),
        .clr_overrun  (clr),
        .bram_wr_en   (bram_wr_en),
        .bram_wr_addr (bram_wr_addr),
        .bram_wr_data (bram_wr_data),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_addr (bram_rd_addr),
        .tap_valid    (tap_valid),
        .tap_index    (tap_index),
        .tap_first    (tap_first),
        .tap_last     (tap_last),
        .busy         (busy),
        .primed       (primed),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {int cyc; int addr; int data;} ev_t;
    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t tap_q[$];
    ev_t mev;

    // Reference model: sweeps are scheduled from arrival times, not from an FSM.
    int m_wptr, m_cnt, m_ovr;
    int m_pend_v, m_pend_addr, m_pend_start;
    int m_have, m_last_start;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_wptr = 0; m_cnt = 0; m_ovr = 0;
        m_pend_v = 0; m_pend_addr = 0; m_pend_start = 0;
        m_have = 0; m_last_start = 0;
        wr_q.delete(); rd_q.delete(); tap_q.delete();
    endtask

    task automatic commit_sweep();
        for (int k = 0; k < TAPS; k++) begin
            rd_q.push_back('{m_pend_start + k, (m_pend_addr + ML - k) % ML, k});
            tap_q.push_back('{m_pend_start + 1 + k, 0, k});
        end
        m_have = 1;
        m_last_start = m_pend_start;
        m_pend_v = 0;
    endtask

    task automatic step(input bit v, input bit e, input bit c, input int data);
        int start;
        bit drop;
        @(posedge clk);
        #1;
        if (rst_n) begin
            chk("overrun", int'(overrun), m_ovr);
            chk("primed", int'(primed), int'(m_cnt >= TAPS));
            chk("busy", int'(busy), int'(m_pend_v != 0 ||
                (m_have != 0 && cyc >= m_last_start && cyc <= m_last_start + TAPS)));
        end
        if (m_pend_v != 0 && cyc >= m_pend_start - 1) commit_sweep();
        sv = v; en = e; clr = c; sin = 16'(data);
        drop = 1'b0;
        if (rst_n && v && e) begin
            wr_q.push_back('{cyc + 1, m_wptr, data});
            drop = (m_pend_v != 0);
            start = cyc + 2;
            if (m_have != 0 && m_last_start + TAPS > start) start = m_last_start + TAPS;
            m_pend_v = 1; m_pend_addr = m_wptr; m_pend_start = start;
            m_wptr = (m_wptr + 1) % ML;
            if (m_cnt < TAPS) m_cnt++;
        end
        if (drop) m_ovr = 1;
        else if (c && rst_n) m_ovr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic sample();
        step(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 65535)));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'(|{bram_wr_en, bram_wr_addr, bram_wr_data, bram_rd_en, bram_rd_addr,
                         tap_valid, tap_index, tap_first, tap_last, busy, primed, overrun}), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                chk("wr_missing", 0, 1); void'(wr_q.pop_front());
            end
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                chk("rd_missing", 0, 1); void'(rd_q.pop_front());
            end
            while (tap_q.size() > 0 && tap_q[0].cyc < cyc) begin
                chk("tap_missing", 0, 1); void'(tap_q.pop_front());
            end
            if (bram_wr_en) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mev = wr_q.pop_front();
                    chk("wr_cycle", cyc, mev.cyc);
                    chk("wr_addr", int'(bram_wr_addr), mev.addr);
                    chk("wr_data", int'(bram_wr_data), mev.data);
                end
            end
            if (bram_rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    mev = rd_q.pop_front();
                    chk("rd_cycle", cyc, mev.cyc);
                    chk("rd_addr", int'(bram_rd_addr), mev.addr);
                end
            end
            if (tap_valid) begin
                if (tap_q.size() == 0) chk("tap_unexpected", 1, 0);
                else begin
                    mev = tap_q.pop_front();
                    chk("tap_cycle", cyc, mev.cyc);
                    chk("tap_index", int'(tap_index), mev.data);
                    chk("tap_first", int'(tap_first), int'(mev.data == 0));
                    chk("tap_last", int'(tap_last), int'(mev.data == TAPS - 1));
                end
            end else begin
                chk("tap_flags_idle", int'(tap_first | tap_last), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        model_reset();
        // Reset held with samples toggling
        for (int i = 0; i < 6; i++) begin
            step(i[0], 1'b1, 1'b0, 16'h1234 + i);
            chk_all_zero("reset_outputs");
        end
        sv = 1'b0;
        @(posedge clk); #3; rst_n = 1'b1;

        // Buffer fill with isolated sweeps, then a wrapping sweep from address 0
        for (int i = 0; i <= ML; i++) begin
            sample();
            idle(TAPS + 3);
        end
        // Queued request mid-sweep: back-to-back sweeps, no overrun
        sample(); idle(3); sample(); idle(2 * TAPS + 4);
        // Three requests within one sweep: overrun, newest pend_addr wins
        sample(); idle(1); sample(); idle(1); sample(); idle(TAPS + 4);
        step(1'b0, 1'b1, 1'b1, 0); idle(2);
        // Clear colliding with a new drop: set wins
        sample(); sample(); step(1'b1, 1'b1, 1'b1, 16'h7fff); idle(TAPS + 4);
        step(1'b0, 1'b1, 1'b1, 0); idle(TAPS + 4);

        // Randomized phases of varying density
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 600; i++) begin
                int p;
                p = (ph == 0) ? 8 : (ph == 1) ? 20 : (ph == 2) ? 50 : 12;
                step($urandom_range(0, 99) < p, $urandom_range(0, 9) != 0,
                     $urandom_range(0, 24) == 0, int'($urandom_range(0, 65535)));
            end
        end
        idle(3 * TAPS);

        // Asynchronous reset in the middle of a sweep
        sample();
        t = 0;
        while (!(tap_valid && int'(tap_index) == 3) && t < 100) begin
            idle(1); t++;
        end
        chk("sweep_reached_tap3", int'(t < 100), 1);
        #2; rst_n = 1'b0; #1;
        chk_all_zero("async_reset_outputs");
        model_reset();
        idle(3);
        @(posedge clk); #3; rst_n = 1'b1;
        idle(TAPS + 3);
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 99) < 25, 1'b1, $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 65535)));
        end
        idle(3 * TAPS + 10);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("tap_queue_drained", tap_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
